// File: rtl/countdown_timer_if.sv
// Pushbutton, preset and display signals of the countdown timer.
// The master drives the keys and the preset. The slave (the timer) drives the count and the status.
interface countdown_timer_if;
   logic        KEY_START_N;
   logic        KEY_LOAD_N;
   logic [15:0] preset_bcd;
   logic [15:0] count_bcd;
   logic        running;
   logic        expired;
   logic        done_pulse;

   modport master (
      output KEY_START_N, KEY_LOAD_N, preset_bcd,
      input  count_bcd, running, expired, done_pulse
   );

   modport slave (
      input  KEY_START_N, KEY_LOAD_N, preset_bcd,
      output count_bcd, running, expired, done_pulse
   );
endinterface

// File: rtl/countdown_timer.sv
// 4-digit BCD countdown timer (SS.hh) with synchronised active-low start/pause and load keys.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   countdown_timer_if.slave bus
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state;
   logic [2:0]    start_sync, load_sync;   // [0],[1] synchroniser, [2] previous sample
   logic          start_evt, load_evt;
   logic [PW-1:0] prescaler;
   logic [15:0]   count, reload;
   logic          running_q, expired_q, done_q;
   logic          tick;
   logic [15:0]   count_dec;
   logic          dec_zero;
   logic [15:0]   preset_clamped;

   function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++)
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      return r;
   endfunction

   // NOTE: blocking '=' is correct here: these are locals of a combinational function,
   // evaluated in order; registers below are only ever written with '<='.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         start_sync <= '1;
         load_sync  <= '1;
         start_evt  <= 1'b0;
         load_evt   <= 1'b0;
      end else begin
         start_sync <= {start_sync[1:0], bus.KEY_START_N};
         load_sync  <= {load_sync[1:0], bus.KEY_LOAD_N};
         start_evt  <= start_sync[2] & ~start_sync[1];
         load_evt   <= load_sync[2] & ~load_sync[1];
      end
   end

   assign tick           = (state == RUN) && (prescaler == PRE_MAX);
   assign count_dec      = bcd_dec(count);
   assign dec_zero       = (count_dec == 16'h0000);
   assign preset_clamped = clamp_bcd(bus.preset_bcd);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         count      <= '0;
         reload     <= '0;
         prescaler  <= '0;
         running_q  <= 1'b0;
         expired_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == RUN) prescaler <= tick ? '0 : prescaler + 1'b1;

         if (load_evt) begin
            count     <= preset_clamped;
            reload    <= preset_clamped;
            state     <= IDLE;
            prescaler <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_evt) begin
                     if (count != 16'h0000) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                        prescaler <= '0;
                     end else begin
                        state     <= DONE;
                        expired_q <= 1'b1;
                        done_q    <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (tick) count <= count_dec;
                  if (tick && dec_zero) begin
                     done_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     if (reload != 16'h0000) begin
                        count <= reload;
                        if (start_evt) begin
                           state     <= PAUSE;
                           running_q <= 1'b0;
                        end
                     end else begin
                        state     <= DONE;
                        running_q <= 1'b0;
                        expired_q <= 1'b1;
                     end
`else
                     state     <= DONE;
                     running_q <= 1'b0;
                     expired_q <= 1'b1;
`endif
                  end else if (start_evt) begin
                     // A tick landing with the pause press is applied first (count_dec above).
                     state     <= PAUSE;
                     running_q <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (start_evt) begin
                     state     <= RUN;
                     running_q <= 1'b1;
                  end
               end
               DONE: ;
               default: begin
                  state     <= IDLE;
                  running_q <= 1'b0;
                  expired_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.count_bcd  = count;
   assign bus.running    = running_q;
   assign bus.expired    = expired_q;
   assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised bench for countdown_timer: an integer-valued reference model tracks the key
// latency and the hundredths count. Every output is compared on each falling clock edge.
module tb_countdown_timer;
   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   countdown_timer_if bus ();

   countdown_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: count held as a plain integer number of hundredths.
   typedef struct {
      int       val;
      int       reload;
      int       st;
      int       pre;
      bit       done;
      bit [4:0] hs;   // start key samples, [j] = j edges ago
      bit [4:0] hl;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.val = 0; r.reload = 0; r.st = S_IDLE; r.pre = 0; r.done = 1'b0;
      r.hs = '1; r.hl = '1;
      return r;
   endfunction

   function automatic int clamp_val(input logic [15:0] p);
      int acc, d;
      acc = 0;
      for (int i = 3; i >= 0; i--) begin
         d = int'(p[4*i +: 4]);
         if (d > 9) d = 9;
         acc = acc * 10 + d;
      end
      return acc;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic model_t model_step(input model_t c, input logic ks, input logic kl,
                                         input logic [15:0] p);
      model_t n;
      bit st_ev, ld_ev, tick;
      n      = c;
      n.hs   = {c.hs[3:0], bit'(ks)};
      n.hl   = {c.hl[3:0], bit'(kl)};
      st_ev  = !n.hs[3] && n.hs[4];
      ld_ev  = !n.hl[3] && n.hl[4];
      tick   = (c.st == S_RUN) && (c.pre == DIV - 1);
      n.done = 1'b0;
      if (c.st == S_RUN) n.pre = (c.pre + 1) % DIV;
      if (ld_ev) begin
         n.val = clamp_val(p); n.reload = n.val; n.st = S_IDLE; n.pre = 0;
      end else begin
         case (c.st)
            S_IDLE:
               if (st_ev) begin
                  if (c.val != 0) begin n.st = S_RUN; n.pre = 0; end
                  else begin n.st = S_DONE; n.done = 1'b1; end
               end
            S_RUN: begin
               if (tick) begin
                  n.val = c.val - 1;
                  if (n.val == 0) begin
                     n.done = 1'b1;
                     if (AUTO && c.reload != 0) n.val = c.reload;
                     else n.st = S_DONE;
                  end
               end
               if (n.st == S_RUN && st_ev) n.st = S_PAUSE;
            end
            S_PAUSE: if (st_ev) n.st = S_RUN;
            default: ;
         endcase
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, bus.KEY_START_N, bus.KEY_LOAD_N, bus.preset_bcd);

   always @(negedge clk)
      if (rst_n && chk_en) begin
         check("count",   bus.count_bcd, to_bcd(m.val));
         check("running", {15'b0, bus.running},    {15'b0, m.st == S_RUN});
         check("expired", {15'b0, bus.expired},    {15'b0, m.st == S_DONE});
         check("done",    {15'b0, bus.done_pulse}, {15'b0, m.done});
      end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic press(input bit start, input bit load, input int hold);
      if (start) bus.KEY_START_N = 1'b0;
      if (load)  bus.KEY_LOAD_N  = 1'b0;
      idle(hold);
      bus.KEY_START_N = 1'b1;
      bus.KEY_LOAD_N  = 1'b1;
   endtask

   task automatic load_preset(input logic [15:0] p);
      bus.preset_bcd = p;
      press(1'b0, 1'b1, 1);
      idle(5);
   endtask

   initial begin
      int n;
      int r;
      bus.KEY_START_N = 1'b1;
      bus.KEY_LOAD_N  = 1'b1;
      bus.preset_bcd  = 16'h0000;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      check("rst_count",   bus.count_bcd, 16'h0000);
      check("rst_running", {15'b0, bus.running}, 16'h0000);
      check("rst_expired", {15'b0, bus.expired}, 16'h0000);
      chk_en = 1'b1;

      // Full run from 00.12: 120 clocks after the start event, which lands 3 edges after the press.
      load_preset(16'h0012);
      check("load_0012", bus.count_bcd, 16'h0012);
      press(1'b1, 1'b0, 1);
      n = 0;
      while (!bus.expired && n < 300) begin
         idle(1);
         n++;
      end
      check("expire_seen", {15'b0, bus.expired}, 16'h0001);
      check("expire_lat",  16'(n), 16'd123);
      check("expire_cnt",  bus.count_bcd, 16'h0000);

      load_preset(16'hFFFF);
      check("clamp_ffff", bus.count_bcd, 16'h9999);

      load_preset(16'h1000);
      press(1'b1, 1'b0, 1);
      idle(14);
      check("borrow_1000", bus.count_bcd, 16'h0999);
      press(1'b1, 1'b0, 1);
      idle(5);
      load_preset(16'h0100);
      press(1'b1, 1'b0, 1);
      idle(14);
      check("borrow_0100", bus.count_bcd, 16'h0099);

      // Pause for 50 clocks, then resume. The model checks the remaining prescaler phase.
      load_preset(16'h0500);
      press(1'b1, 1'b0, 1);
      idle(5);
      press(1'b1, 1'b0, 1);
      idle(50);
      check("pause_hold", bus.count_bcd, 16'h0500);
      check("pause_run",  {15'b0, bus.running}, 16'h0000);
      press(1'b1, 1'b0, 1);
      idle(20);

      // Load and start together while running: load wins.
      bus.preset_bcd = 16'h0321;
      press(1'b1, 1'b1, 1);
      idle(6);
      check("ld_st_run", {15'b0, bus.running}, 16'h0000);
      check("ld_st_cnt", bus.count_bcd, 16'h0321);

      press(1'b1, 1'b0, 100);
      idle(2);
      check("held_start", {15'b0, bus.running}, 16'h0001);

      load_preset(16'h0000);
      press(1'b1, 1'b0, 1);
      idle(2);
      check("zero_start_early", {15'b0, bus.expired}, 16'h0000);
      idle(1);
      check("zero_start_done", {15'b0, bus.expired}, 16'h0001);

      // Asynchronous reset in the middle of a run.
      load_preset(16'h0050);
      press(1'b1, 1'b0, 1);
      idle(20);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_count",   bus.count_bcd, 16'h0000);
      check("arst_running", {15'b0, bus.running}, 16'h0000);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 2) begin
            if ($urandom_range(0, 3) == 0) bus.preset_bcd = 16'($urandom);
            else bus.preset_bcd = {8'h00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            press(1'b0, 1'b1, $urandom_range(1, 4));
         end else if (r <= 6) begin
            press(1'b1, 1'b0, $urandom_range(1, 6));
         end else if (r == 7) begin
            bus.preset_bcd = {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            press(1'b1, 1'b1, $urandom_range(1, 3));
         end else begin
            idle($urandom_range(1, 40));
         end
         idle($urandom_range(0, 15));
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
